// File: rtl/acp_mem_responder.sv
// AXI3-subset slave answering ACP master INCR bursts (1-16 beats) from an on-chip memory.
// Read and write channels run independent FSMs; the memory is read-first on collisions.
module acp_mem_responder #(
   parameter int                    ACP_WIDTH  = 64,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [3:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [ACP_WIDTH-1:0]  rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [3:0]            awlen,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ACP_WIDTH-1:0]  wdata,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready
);

   localparam int BYTES = ACP_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

   // One extra bit keeps the window upper bound from overflowing near the top of the address map.
   function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH:0] addr_x;
      logic [ADDR_WIDTH:0] base_x;
      addr_x = {1'b0, addr};
      base_x = {1'b0, BASE_ADDR};
      return (addr_x >= base_x) && (addr_x < (base_x + WIN_BYTES));
   endfunction

   function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] diff;
      diff = addr - BASE_ADDR;
      return diff[OFF_W +: IDX_W];
   endfunction

   logic [ACP_WIDTH-1:0] mem_r [MEM_DEPTH];

   rd_state_t            rd_state_r, rd_state_s;
   logic [IDX_W-1:0]     rd_idx_r;
   logic [3:0]           rd_len_r;
   logic [3:0]           rd_beat_r;
   logic                 rd_ok_r;
   logic                 arready_r, rvalid_r, rlast_r;
   logic [ACP_WIDTH-1:0] rdata_r;
   logic [1:0]           rresp_r;

   wr_state_t            wr_state_r, wr_state_s;
   logic [IDX_W-1:0]     wr_idx_r;
   logic [3:0]           wr_len_r;
   logic [3:0]           wr_beat_r;
   logic                 wr_ok_r;
   logic                 wr_err_r;
   logic                 awready_r, wready_r, bvalid_r;
   logic [1:0]           bresp_r;

   logic                 ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
   logic                 rd_last_s, wr_last_s, wlast_bad_s, mem_we_s;

   assign arready = arready_r;
   assign rvalid  = rvalid_r;
   assign rdata   = rdata_r;
   assign rresp   = rresp_r;
   assign rlast   = rlast_r;
   assign awready = awready_r;
   assign wready  = wready_r;
   assign bvalid  = bvalid_r;
   assign bresp   = bresp_r;

   assign ar_hs_s     = arvalid && arready_r;
   assign r_hs_s      = rvalid_r && rready;
   assign aw_hs_s     = awvalid && awready_r;
   assign w_hs_s      = wvalid && wready_r;
   assign b_hs_s      = bvalid_r && bready;
   assign rd_last_s   = (rd_beat_r == rd_len_r);
   assign wr_last_s   = (wr_beat_r == wr_len_r);
   assign wlast_bad_s = (wlast != wr_last_s);
   assign mem_we_s    = RST_N && (wr_state_r == W_DATA) && w_hs_s && wr_ok_r;

   // Read channel next-state.
   always_comb begin
      rd_state_s = rd_state_r;
      case (rd_state_r)
         R_IDLE: begin
            if (ar_hs_s) rd_state_s = R_FETCH;
            else         rd_state_s = R_IDLE;
         end
         R_FETCH: rd_state_s = R_DATA;
         R_DATA: begin
            if (r_hs_s) rd_state_s = rd_last_s ? R_IDLE : R_FETCH;
            else        rd_state_s = R_DATA;
         end
         default: rd_state_s = R_IDLE;
      endcase
   end

   // Read channel state, burst context and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_state_r <= R_IDLE;
         rd_idx_r   <= {IDX_W{1'b0}};
         rd_len_r   <= 4'd0;
         rd_beat_r  <= 4'd0;
         rd_ok_r    <= 1'b0;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rlast_r    <= 1'b0;
         rdata_r    <= {ACP_WIDTH{1'b0}};
         rresp_r    <= RESP_OKAY;
      end else begin
         rd_state_r <= rd_state_s;
         arready_r  <= (rd_state_s == R_IDLE);
         rvalid_r   <= (rd_state_s == R_DATA);
         case (rd_state_r)
            R_IDLE: begin
               if (ar_hs_s) begin
                  rd_idx_r  <= addr_index(araddr);
                  rd_len_r  <= arlen;
                  rd_ok_r   <= addr_in_range(araddr);
                  rd_beat_r <= 4'd0;
               end
            end
            R_FETCH: begin
               rdata_r <= rd_ok_r ? mem_r[rd_idx_r] : {ACP_WIDTH{1'b0}};
               rresp_r <= rd_ok_r ? RESP_OKAY : RESP_DECERR;
               rlast_r <= rd_last_s;
            end
            R_DATA: begin
               if (r_hs_s && !rd_last_s) begin
                  rd_beat_r <= rd_beat_r + 4'd1;
                  rd_idx_r  <= rd_idx_r + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Write channel next-state; awlen alone decides where the burst ends.
   always_comb begin
      wr_state_s = wr_state_r;
      case (wr_state_r)
         W_IDLE: begin
            if (aw_hs_s) wr_state_s = W_DATA;
            else         wr_state_s = W_IDLE;
         end
         W_DATA: begin
            if (w_hs_s && wr_last_s) wr_state_s = W_RESP;
            else                     wr_state_s = W_DATA;
         end
         W_RESP: begin
            if (b_hs_s) wr_state_s = W_IDLE;
            else        wr_state_s = W_RESP;
         end
         default: wr_state_s = W_IDLE;
      endcase
   end

   // Write channel state, burst context, error tracking and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_state_r <= W_IDLE;
         wr_idx_r   <= {IDX_W{1'b0}};
         wr_len_r   <= 4'd0;
         wr_beat_r  <= 4'd0;
         wr_ok_r    <= 1'b0;
         wr_err_r   <= 1'b0;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
      end else begin
         wr_state_r <= wr_state_s;
         awready_r  <= (wr_state_s == W_IDLE);
         wready_r   <= (wr_state_s == W_DATA);
         bvalid_r   <= (wr_state_s == W_RESP);
         case (wr_state_r)
            W_IDLE: begin
               if (aw_hs_s) begin
                  wr_idx_r  <= addr_index(awaddr);
                  wr_len_r  <= awlen;
                  wr_ok_r   <= addr_in_range(awaddr);
                  wr_err_r  <= 1'b0;
                  wr_beat_r <= 4'd0;
               end
            end
            W_DATA: begin
               if (w_hs_s) begin
                  wr_err_r  <= wr_err_r | wlast_bad_s;
                  wr_beat_r <= wr_beat_r + 4'd1;
                  wr_idx_r  <= wr_idx_r + IDX_W'(1);
                  // The response must include a mismatch seen on the final beat itself.
                  if (wr_last_s) begin
                     if (!wr_ok_r)                     bresp_r <= RESP_DECERR;
                     else if (wr_err_r || wlast_bad_s) bresp_r <= RESP_SLVERR;
                     else                              bresp_r <= RESP_OKAY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Memory array: never reset, written only for in-range bursts.
   always_ff @(posedge CLK) begin
      if (mem_we_s) begin
         mem_r[wr_idx_r] <= wdata;
      end
   end

endmodule

// File: tb/tb_acp_mem_responder.sv
// Directed bench for acp_mem_responder: cycle-accurate burst checks with hand-computed data.
module tb_acp_mem_responder;

   logic        CLK;
   logic        RST_N;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int n_cmp;
   int n_err;

   acp_mem_responder #(
      .ACP_WIDTH (64),
      .ADDR_WIDTH(32),
      .MEM_DEPTH (1024),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] len,
                           input logic [63:0] d0, input int wlast_at, input logic [1:0] exp_resp);
      int n;
      n = 0;
      while (!awready && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, "_awready"}, 64'(awready), 64'd1);
      awaddr  = addr;
      awlen   = len;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check_val({tag, "_wready_on"}, 64'(wready), 64'd1);
      for (int i = 0; i <= int'(len); i++) begin
         wdata  = d0 + 64'(i);
         wlast  = (i == wlast_at);
         wvalid = 1'b1;
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      check_val({tag, "_wready_off"}, 64'(wready), 64'd0);
      check_val({tag, "_bvalid"}, 64'(bvalid), 64'd1);
      check_val({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
      tick();
      check_val({tag, "_bvalid_pulse"}, 64'(bvalid), 64'd0);
      check_val({tag, "_awready_back"}, 64'(awready), 64'd1);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] len,
                          input logic [63:0] d0, input logic [1:0] exp_resp, input int stall_at);
      int n;
      logic [63:0] exp_d;
      n = 0;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, "_arready"}, 64'(arready), 64'd1);
      araddr  = addr;
      arlen   = len;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check_val({tag, "_rvalid_t1"}, 64'(rvalid), 64'd0);
      tick();
      for (int i = 0; i <= int'(len); i++) begin
         exp_d = (exp_resp == 2'b11) ? 64'd0 : d0 + 64'(i);
         check_val({tag, "_rvalid"}, 64'(rvalid), 64'd1);
         check_val({tag, "_rdata"}, rdata, exp_d);
         check_val({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
         check_val({tag, "_rlast"}, 64'(rlast), 64'(i == int'(len)));
         if (i == stall_at) begin
            rready = 1'b0;
            repeat (5) begin
               tick();
               check_val({tag, "_stall_rvalid"}, 64'(rvalid), 64'd1);
               check_val({tag, "_stall_rdata"}, rdata, exp_d);
            end
            rready = 1'b1;
         end
         tick();
         check_val({tag, "_rvalid_gap"}, 64'(rvalid), 64'd0);
         if (i != int'(len)) tick();
      end
      check_val({tag, "_arready_back"}, 64'(arready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_arready"}, 64'(arready), 64'd0);
      check_val({tag, "_awready"}, 64'(awready), 64'd0);
      check_val({tag, "_rvalid"},  64'(rvalid),  64'd0);
      check_val({tag, "_rlast"},   64'(rlast),   64'd0);
      check_val({tag, "_rdata"},   rdata,        64'd0);
      check_val({tag, "_rresp"},   64'(rresp),   64'd0);
      check_val({tag, "_wready"},  64'(wready),  64'd0);
      check_val({tag, "_bvalid"},  64'(bvalid),  64'd0);
      check_val({tag, "_bresp"},   64'(bresp),   64'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      RST_N   = 1'b0;
      araddr  = 32'd0;
      arlen   = 4'd0;
      arvalid = 1'b0;
      rready  = 1'b1;
      awaddr  = 32'd0;
      awlen   = 4'd0;
      awvalid = 1'b0;
      wdata   = 64'd0;
      wlast   = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      repeat (2) tick();
      check_reset_outputs("rst");
      RST_N = 1'b1;
      tick();
      check_val("post_rst_arready", 64'(arready), 64'd1);
      check_val("post_rst_awready", 64'(awready), 64'd1);

      // Single beat, then byte-offset bits ignored on the read address.
      do_write("single", 32'h40, 4'd0, 64'hDEAD_BEEF_0123_4567, 0, 2'b00);
      do_read ("single_rd", 32'h40, 4'd0, 64'hDEAD_BEEF_0123_4567, 2'b00, -1);
      do_read ("lowbits_rd", 32'h43, 4'd0, 64'hDEAD_BEEF_0123_4567, 2'b00, -1);

      // 16-beat burst, plain and with a 5-cycle stall on beat 3.
      do_write("b16", 32'h80, 4'd15, 64'd0, 15, 2'b00);
      do_read ("b16_rd", 32'h80, 4'd15, 64'd0, 2'b00, -1);
      do_read ("stall_rd", 32'h80, 4'd15, 64'd0, 2'b00, 3);

      // Out of range: 0x2000 aliases index 0, which must stay untouched.
      do_write("base", 32'h0, 4'd3, 64'h1000, 3, 2'b00);
      do_write("oor", 32'h2000, 4'd3, 64'hAAAA_0000, 3, 2'b11);
      do_read ("oor_rd", 32'h2000, 4'd3, 64'd0, 2'b11, -1);
      do_read ("unchanged_rd", 32'h0, 4'd3, 64'h1000, 2'b00, -1);

      // wlast on beat 1 of a 4-beat burst: all beats land, SLVERR.
      do_write("wlast", 32'h100, 4'd3, 64'h100, 1, 2'b10);
      do_read ("wlast_rd", 32'h100, 4'd3, 64'h100, 2'b00, -1);

      // Index wraps from 1023 to 0.
      do_write("wrap", 32'h1FF8, 4'd1, 64'h77, 1, 2'b00);
      do_read ("wrap_rd", 32'h1FF8, 4'd1, 64'h77, 2'b00, -1);
      do_read ("wrap0_rd", 32'h0, 4'd0, 64'h78, 2'b00, -1);

      // Reset during beat 2 of an 8-beat write.
      awaddr  = 32'h200;
      awlen   = 4'd7;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wdata  = 64'h500 + 64'(i);
         wlast  = 1'b0;
         wvalid = 1'b1;
         tick();
      end
      wdata = 64'h502;
      RST_N = 1'b0;
      tick();
      RST_N  = 1'b1;
      wvalid = 1'b0;
      check_reset_outputs("midrst");
      tick();
      check_val("midrst_awready", 64'(awready), 64'd1);
      check_val("midrst_no_bvalid", 64'(bvalid), 64'd0);
      do_read ("midrst_rd", 32'h200, 4'd1, 64'h500, 2'b00, -1);
      do_write("midrst_new", 32'h200, 4'd0, 64'h1234, 0, 2'b00);
      do_read ("midrst_new_rd", 32'h200, 4'd0, 64'h1234, 2'b00, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/acp_mem_responder.md
# acp_mem_responder

AXI3-subset slave that answers the burst reads and writes issued by the PL-side ACP master, backed by a dual-port on-chip memory. It sits in place of the PS7 ACP port, both as a standalone simulation and bring-up target and as a scratch-memory responder in PL-only builds. It has independent read and write channel FSMs and supports INCR bursts of 1–16 beats, with OKAY/SLVERR/DECERR responses.

## Interface
- ACP_WIDTH, 64: data bus width in bits; BYTES = ACP_WIDTH/8.
- ADDR_WIDTH, 32: address width.
- MEM_DEPTH, 1024: memory depth in ACP_WIDTH words; power of 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_DEPTH*BYTES.
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- araddr  in  ADDR_WIDTH  read burst start byte address.
- arlen  in  4  read beats minus 1.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  ACP_WIDTH  read data.
- rresp  out  2  read response (00 OKAY, 11 DECERR).
- rlast  out  1  final read beat.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts read data.
- awaddr  in  ADDR_WIDTH  write burst start byte address.
- awlen  in  4  write beats minus 1.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  ACP_WIDTH  write data.
- wlast  in  1  master's last-beat marker.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response (00 OKAY, 10 SLVERR, 11 DECERR).
- bvalid  out  1  write response valid.
- bready  in  1  master accepts response; tie high for masters that only count bvalid.

## Operation
- Reset values, all outputs registered: arready=0, awready=0, rvalid=0, rlast=0, rdata=0, rresp=00, wready=0, bvalid=0, bresp=00. Beat counters are 0 and both FSMs are in IDLE. Memory contents are not reset.
- Word index = ((addr - BASE_ADDR) >> log2(BYTES)) mod MEM_DEPTH.
  - Byte-offset low bits are ignored.
  - Each beat adds 1 to the index; the index wraps at MEM_DEPTH.
- Window check uses the burst start address only: in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*BYTES.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch the index, arlen, and the in-range flag; -> R_FETCH.
  - R_FETCH: arready=0; drive memory read address; -> R_DATA.
  - R_DATA: rvalid=1. rdata = memory word, or 0 if out of range. rresp=00, or 11 if out of range. rlast=1 iff beat==len.
    - rdata, rresp and rlast hold stable while rready=0.
    - On rready with beat<len: increment beat and index; -> R_FETCH.
    - On rready with beat==len: -> R_IDLE.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch the index, awlen and the in-range flag; clear the error flag; -> W_DATA.
  - W_DATA: wready=1. Each cycle with wvalid:
    - Write wdata to memory only if in range.
    - Set the error flag if wlast != (beat==len).
    - Increment beat and index.
    - At beat==len: -> W_RESP.
    - Burst length is governed by awlen only; wlast never terminates a burst.
  - W_RESP: wready=0, bvalid=1. bresp priority: DECERR (out of range) > SLVERR (wlast mismatch) > OKAY. On bready: -> W_IDLE.
- Channels are fully independent and may run concurrently.
- Same-word read/write collision: the memory is read-first, so a read in the same cycle as a write returns the old data.
- Reset mid-burst: all FSMs return to IDLE and all valids drop on the next edge. The partial burst is abandoned with no response; memory writes already committed remain.

## Timing
- Read:
  - AR handshake at cycle T; first rvalid at T+2.
  - After a beat handshake at cycle U, the next rvalid is at U+2.
  - Throughput is 1 beat per 2 cycles with rready held high.
  - arready reasserts the cycle after the final-beat handshake.
- Write:
  - AW handshake at T; wready=1 at T+1.
  - Throughput is 1 beat per cycle.
  - A beat written at cycle V is visible to an R_FETCH at V+1 or later.
  - After the final beat at cycle F: wready=0 and bvalid=1 at F+1.
  - With bready=1, bvalid is a single-cycle pulse; awready=1 at F+2.
- A valid never depends combinationally on its ready; no outputs are combinational.

## Test plan
- Single beat:
  - Stimulus: AW 0x40, len 0; W 0xDEADBEEF_01234567 with wlast=1.
  - Response: bresp=00, one bvalid pulse. AR 0x40, len 0 then returns the same data with rlast=1 at T+2.
- 16-beat burst:
  - Stimulus: write 16 beats at 0x80 with data=beat number; then read 16 beats.
  - Response: reads return 0..15 in order; rlast only on beat 15; each beat spaced 2 cycles.
- rready stall:
  - Stimulus: rready low for 5 cycles during beat 3 of a 16-beat read.
  - Response: rvalid stays high and rdata=3 holds through the stall; no beat is skipped or duplicated.
- Out of range:
  - Stimulus: AW at BASE_ADDR+MEM_DEPTH*BYTES, len 3.
  - Response: bresp=11 and memory unchanged. An AR to the same address returns 4 beats of 0 with rresp=11.
- wlast misuse:
  - Stimulus: 4-beat write with wlast asserted on beat 1.
  - Response: all 4 beats are written; bresp=10.
- Reset mid-burst:
  - Stimulus: RST_N low for 1 cycle during beat 2 of an 8-beat write.
  - Response: all outputs return to reset values; no bvalid; beats 0–1 stay in memory; a new AW is accepted afterwards.
